// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 fetch front end.
//   XLEN          : address / instruction width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   fetch_entry_t : one buffered instruction together with its PC
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: circular buffer with head/tail pointers, occupancy count and a
// synchronous clear that takes priority over push and pop.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (pointers/count only)
//   clr_i             drop all entries this cycle
//   push_i, data_i    write one entry at the tail (caller guarantees space)
//   pop_i             remove the head entry (caller guarantees non-empty)
//   data_o            current head entry
//   count_o, empty_o  occupancy
module sync_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Issues in-order word requests to a
// variable-latency instruction memory, buffers returned words with their PCs
// and hands them to decode over a valid/ready handshake. A redirect flushes
// the buffer and arranges for all in-flight responses to be discarded.
// Optional feature macro: FETCH_PERF_EN adds stall/flush performance counters.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc     taken branch/jump from execute
//   req_valid/req_ready/req_addr    memory request channel
//   resp_valid/resp_data            memory response (in request order)
//   instr_valid/instr_ready         decode handshake
//   instr, instr_pc, instr_pc_plus4 head instruction (NOP when not valid)
//   perf_stall_cnt, perf_flush_cnt  [FETCH_PERF_EN] saturating counters
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     head_entry;
  fetch_entry_t     push_entry;

  logic             resp_live;
  logic             resp_drop;
  logic             push;
  logic             pop;
  logic             issue;
  logic [CNT_W:0]   credit_used;
  logic [XLEN-1:0]  redirect_aligned;
  logic             unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign push_entry           = '{pc: resp_pc_q, instr: resp_data};

  // Buffer slots are reserved at issue time: count + outstanding never
  // exceeds DEPTH, so every response that is kept has a free slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};

  always_comb begin
    // A response with nothing outstanding is stray and is ignored.
    resp_live   = resp_valid && (outstanding_q != '0);
    resp_drop   = resp_live && (drop_cnt_q != '0);
    push        = resp_live && (drop_cnt_q == '0) && !redirect_valid;
    instr_valid = !reset && !redirect_valid && !fifo_empty;
    pop         = instr_valid && instr_ready;
    req_valid   = !reset && !redirect_valid
                  && (credit_used < (CNT_W+1)'(DEPTH))
                  && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    issue       = req_valid && req_ready;

    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp_live);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old
      // path; a response arriving right now is discarded as well.
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_cnt_d = outstanding_q - CNT_W'(resp_live);
    end else begin
      if (issue)     fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)      resp_pc_d  = resp_pc_q + XLEN'(4);
      if (resp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign req_addr       = fetch_pc_q;
  assign instr          = instr_valid ? head_entry.instr : NOP_INSTR;
  assign instr_pc       = head_entry.pc;
  assign instr_pc_plus4 = head_entry.pc + XLEN'(4);

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!instr_valid && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
